// File: rtl/cfg_frame_sequencer.sv
// cfg_frame_sequencer
//
// Frame-synchronous loader for the parameter register file (homographies,
// DfDD A/B, ROI corners, confidence). Host register writes are buffered in a
// FIFO. A host commit arms the batch. The batch is replayed on the
// register-file write port, one entry per cycle, starting at the next
// frame_start_i. As a result, coefficient changes never land mid-frame.
//
// Optional feature: define CFG_SEQ_WATCHDOG_EN to enable the ARMED watchdog.
// When the watchdog counter reaches WATCHDOG_CYCLES with no frame_start_i,
// the drain is forced and the sticky timeout_o flag is set.
//
// Ports:
//   clk_i          single clock, all logic on posedge
//   rst_i          synchronous, active-high reset
//   host_addr_i    host write address
//   host_data_i    host write data
//   host_valid_i   host write request
//   host_ready_o   write accepted when valid & ready (IDLE and FIFO not full)
//   commit_i       1-cycle pulse: arm the current batch
//   frame_start_i  1-cycle pulse at the frame boundary
//   cmd_addr_o     register-file write address (registered)
//   cmd_data_o     register-file write data (registered)
//   cmd_valid_o    register-file write strobe (registered, no backpressure)
//   busy_o         high in ARMED or DRAIN
//   done_o         1-cycle pulse: batch fully issued
//   level_o        FIFO occupancy
//   timeout_o      sticky watchdog flag (constant 0 without the macro)
module cfg_frame_sequencer #(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DEPTH           = 64,
  parameter int unsigned WATCHDOG_CYCLES = 1_000_000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ADDR_WIDTH-1:0]     host_addr_i,
  input  logic [DATA_WIDTH-1:0]     host_data_i,
  input  logic                      host_valid_i,
  output logic                      host_ready_o,
  input  logic                      commit_i,
  input  logic                      frame_start_i,
  output logic [ADDR_WIDTH-1:0]     cmd_addr_o,
  output logic [DATA_WIDTH-1:0]     cmd_data_o,
  output logic                      cmd_valid_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [$clog2(DEPTH):0]    level_o,
  output logic                      timeout_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StArmed, StDrain} state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]       level_q;
  logic [ADDR_WIDTH-1:0] cmd_addr_q;
  logic [DATA_WIDTH-1:0] cmd_data_q;
  logic                  cmd_valid_q;
  logic                  done_q, done_d;

  logic full, empty, push, pop, start, wd_fire;

  assign full         = (level_q == LvlW'(DEPTH));
  assign empty        = (level_q == '0);
  assign host_ready_o = (state_q == StIdle) && !full;
  assign push         = host_valid_i && host_ready_o;
  // A watchdog expiry is treated exactly like a frame boundary.
  assign start        = (state_q == StArmed) && (frame_start_i || wd_fire);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (commit_i) begin
          // An entry pushed this cycle belongs to the batch, so the batch
          // is empty only when nothing is stored and nothing is arriving.
          if (empty && !push) begin
            done_d = 1'b1;
          end else begin
            state_d = StArmed;
          end
        end
      end
      StArmed: begin
        if (start) begin
          // Pop on the transition edge so the first write appears at T+1.
          state_d = StDrain;
          pop     = !empty;
        end
      end
      StDrain: begin
        if (!empty) begin
          pop = 1'b1;
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Storage is not reset: only the pointers and level define its contents.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= host_addr_i;
      data_mem[wr_ptr_q] <= host_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      cmd_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= pop;
      done_q      <= done_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        level_q  <= level_q + 1'b1;
      end else if (pop) begin
        level_q  <= level_q - 1'b1;
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        cmd_addr_q <= addr_mem[rd_ptr_q];
        cmd_data_q <= data_mem[rd_ptr_q];
      end
    end
  end

`ifdef CFG_SEQ_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(WATCHDOG_CYCLES) + 1;

  logic [WdW-1:0] wd_cnt_q;
  logic           timeout_q;

  assign wd_fire = (state_q == StArmed) && (wd_cnt_q == WdW'(WATCHDOG_CYCLES - 1));

  // Counter is held at zero outside ARMED, so it starts from zero on entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == StArmed) begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
      end else begin
        wd_cnt_q <= '0;
      end
      if (wd_fire && !frame_start_i) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_watchdog;

  assign wd_fire         = 1'b0;
  assign timeout_o       = 1'b0;
  assign unused_watchdog = ^WATCHDOG_CYCLES;
`endif

  assign cmd_addr_o  = cmd_addr_q;
  assign cmd_data_o  = cmd_data_q;
  assign cmd_valid_o = cmd_valid_q;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign level_o     = level_q;

endmodule

// File: tb/tb_cfg_frame_sequencer.sv
// Directed testbench for cfg_frame_sequencer. Inputs are driven 1 time unit
// after each rising edge. Outputs are sampled at the same point, well away
// from the next edge. The watchdog scenario runs only when
// CFG_SEQ_WATCHDOG_EN is defined.
module tb_cfg_frame_sequencer;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_data = '0;
  logic          host_valid = 1'b0;
  logic          host_ready;
  logic          commit = 1'b0;
  logic          frame_start = 1'b0;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          cmd_valid;
  logic          busy;
  logic          done;
  logic [6:0]    level;
  logic          timeout;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  cfg_frame_sequencer #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .DEPTH           (DEPTH),
    .WATCHDOG_CYCLES (100)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .host_addr_i   (host_addr),
    .host_data_i   (host_data),
    .host_valid_i  (host_valid),
    .host_ready_o  (host_ready),
    .commit_i      (commit),
    .frame_start_i (frame_start),
    .cmd_addr_o    (cmd_addr),
    .cmd_data_o    (cmd_data),
    .cmd_valid_o   (cmd_valid),
    .busy_o        (busy),
    .done_o        (done),
    .level_o       (level),
    .timeout_o     (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst         = 1'b1;
    host_valid  = 1'b0;
    commit      = 1'b0;
    frame_start = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_addr  = a;
    host_data  = d;
    host_valid = 1'b1;
    step();
    host_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if (host_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_host_ready: got %b expected 1", host_ready);
    end
    tests_run++;
    if ({cmd_valid, cmd_addr, cmd_data} !== {1'b0, 16'h0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_cmd: got v=%b a=%h d=%h expected v=0 a=0 d=0",
               cmd_valid, cmd_addr, cmd_data);
    end
    tests_run++;
    if ({busy, done, timeout} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: got busy/done/timeout=%b expected 000", {busy, done, timeout});
    end
    tests_run++;
    if (level !== 7'd0) begin
      tests_failed++;
      $display("FAIL reset_level: got %0d expected 0", level);
    end
  endtask

  task automatic test_basic();
    logic [AW-1:0] ea [3];
    logic [DW-1:0] ed [3];
    ea = '{16'h0050, 16'h0060, 16'h0081};
    ed = '{32'h0000_0123, 32'h0000_00C8, 32'h0000_0010};
    for (int i = 0; i < 3; i++) push(ea[i], ed[i]);
    tests_run++;
    if (level !== 7'd3) begin
      tests_failed++;
      $display("FAIL basic_level: got %0d expected 3", level);
    end
    commit = 1'b1;
    step();
    commit = 1'b0;
    tests_run++;
    if ({busy, host_ready, done} !== 3'b100) begin
      tests_failed++;
      $display("FAIL basic_armed: got busy/ready/done=%b expected 100", {busy, host_ready, done});
    end
    // Stay armed a few cycles; nothing may be issued before the frame.
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (cmd_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL basic_armed_idle[%0d]: got cmd_valid=%b expected 0", i, cmd_valid);
      end
    end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({cmd_valid, cmd_addr, cmd_data} !== {1'b1, ea[i], ed[i]}) begin
        tests_failed++;
        $display("FAIL basic_cmd[%0d]: got v=%b a=%h d=%h expected v=1 a=%h d=%h",
                 i, cmd_valid, cmd_addr, cmd_data, ea[i], ed[i]);
      end
      step();
    end
    tests_run++;
    if ({done, cmd_valid, busy, host_ready, timeout} !== 5'b10010 || level !== 7'd0) begin
      tests_failed++;
      $display("FAIL basic_done: got done/valid/busy/ready/timeout=%b level=%0d expected 10010 0",
               {done, cmd_valid, busy, host_ready, timeout}, level);
    end
    step();
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done_pulse: got done=%b expected 0", done);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) push(16'h0100 + 16'(i), 32'hD000_0000 + 32'(i));
    tests_run++;
    if (level !== 7'd64 || host_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_full: got level=%0d ready=%b expected 64 0", level, host_ready);
    end
    // A 65th write is presented and must wait rather than be dropped.
    host_addr  = 16'hBEEF;
    host_data  = 32'hCAFE_F00D;
    host_valid = 1'b1;
    step();
    step();
    tests_run++;
    if (level !== 7'd64 || host_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_stall: got level=%0d ready=%b expected 64 0", level, host_ready);
    end
    commit = 1'b1;
    step();
    commit      = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      tests_run++;
      if ({cmd_valid, cmd_addr, cmd_data} !==
          {1'b1, 16'h0100 + 16'(i), 32'hD000_0000 + 32'(i)}) begin
        tests_failed++;
        $display("FAIL fill_cmd[%0d]: got v=%b a=%h d=%h expected v=1 a=%h d=%h",
                 i, cmd_valid, cmd_addr, cmd_data, 16'h0100 + 16'(i), 32'hD000_0000 + 32'(i));
      end
      step();
    end
    tests_run++;
    if ({done, cmd_valid, host_ready} !== 3'b101) begin
      tests_failed++;
      $display("FAIL fill_done: got done/valid/ready=%b expected 101", {done, cmd_valid, host_ready});
    end
    // The held write is accepted on this edge.
    step();
    host_valid = 1'b0;
    tests_run++;
    if (level !== 7'd1) begin
      tests_failed++;
      $display("FAIL fill_held_level: got %0d expected 1", level);
    end
    commit = 1'b1;
    step();
    commit      = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    tests_run++;
    if ({cmd_valid, cmd_addr, cmd_data} !== {1'b1, 16'hBEEF, 32'hCAFE_F00D}) begin
      tests_failed++;
      $display("FAIL fill_held_cmd: got v=%b a=%h d=%h expected v=1 a=beef d=cafef00d",
               cmd_valid, cmd_addr, cmd_data);
    end
    step();
    tests_run++;
    if ({done, cmd_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL fill_held_done: got done/valid=%b expected 10", {done, cmd_valid});
    end
    step();
  endtask

  task automatic test_simultaneous();
    push(16'h0070, 32'h0000_0007);
    // A frame boundary while idle must not start a drain.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    tests_run++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0 || level !== 7'd1) begin
      tests_failed++;
      $display("FAIL idle_frame: got valid=%b busy=%b level=%0d expected 0 0 1",
               cmd_valid, busy, level);
    end
    host_addr  = 16'h00A3;
    host_data  = 32'h0000_3C00;
    host_valid = 1'b1;
    commit     = 1'b1;
    step();
    host_valid = 1'b0;
    commit     = 1'b0;
    tests_run++;
    if (level !== 7'd2 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL push_commit: got level=%0d busy=%b expected 2 1", level, busy);
    end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    tests_run++;
    if ({cmd_valid, cmd_addr, cmd_data} !== {1'b1, 16'h0070, 32'h0000_0007}) begin
      tests_failed++;
      $display("FAIL simul_cmd0: got v=%b a=%h d=%h expected v=1 a=0070 d=00000007",
               cmd_valid, cmd_addr, cmd_data);
    end
    commit = 1'b1;
    step();
    commit = 1'b0;
    tests_run++;
    if ({cmd_valid, cmd_addr, cmd_data} !== {1'b1, 16'h00A3, 32'h0000_3C00}) begin
      tests_failed++;
      $display("FAIL simul_cmd1: got v=%b a=%h d=%h expected v=1 a=00a3 d=00003c00",
               cmd_valid, cmd_addr, cmd_data);
    end
    step();
    tests_run++;
    if ({done, cmd_valid, busy} !== 3'b100) begin
      tests_failed++;
      $display("FAIL simul_done: got done/valid/busy=%b expected 100", {done, cmd_valid, busy});
    end
    step();
    tests_run++;
    if ({done, busy, host_ready} !== 3'b001) begin
      tests_failed++;
      $display("FAIL drain_commit_ignored: got done/busy/ready=%b expected 001",
               {done, busy, host_ready});
    end
  endtask

  task automatic test_empty_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
    tests_run++;
    if ({done, busy, cmd_valid} !== 3'b100) begin
      tests_failed++;
      $display("FAIL empty_commit: got done/busy/valid=%b expected 100", {done, busy, cmd_valid});
    end
    step();
    tests_run++;
    if ({done, busy, cmd_valid} !== 3'b000) begin
      tests_failed++;
      $display("FAIL empty_commit_after: got done/busy/valid=%b expected 000",
               {done, busy, cmd_valid});
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 5; i++) push(16'h0200 + 16'(i), 32'h0000_0A00 + 32'(i));
    commit = 1'b1;
    step();
    commit      = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    tests_run++;
    if ({cmd_valid, cmd_addr} !== {1'b1, 16'h0200}) begin
      tests_failed++;
      $display("FAIL abort_cmd0: got v=%b a=%h expected v=1 a=0200", cmd_valid, cmd_addr);
    end
    step();
    tests_run++;
    if ({cmd_valid, cmd_addr} !== {1'b1, 16'h0201}) begin
      tests_failed++;
      $display("FAIL abort_cmd1: got v=%b a=%h expected v=1 a=0201", cmd_valid, cmd_addr);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (cmd_valid !== 1'b0 || level !== 7'd0 || busy !== 1'b0 || host_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL abort_after[%0d]: got valid=%b level=%0d busy=%b ready=%b expected 0 0 0 1",
                 i, cmd_valid, level, busy, host_ready);
      end
      step();
    end
  endtask

`ifdef CFG_SEQ_WATCHDOG_EN
  task automatic test_watchdog();
    push(16'h0300, 32'h0000_0001);
    push(16'h0301, 32'h0000_0002);
    commit = 1'b1;
    step();
    commit = 1'b0;
    // 99 more cycles in ARMED before the expiry edge.
    for (int i = 0; i < 99; i++) step();
    tests_run++;
    if (cmd_valid !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL wd_before: got valid=%b timeout=%b busy=%b expected 0 0 1",
               cmd_valid, timeout, busy);
    end
    step();
    tests_run++;
    if ({cmd_valid, cmd_addr, timeout} !== {1'b1, 16'h0300, 1'b1}) begin
      tests_failed++;
      $display("FAIL wd_cmd0: got v=%b a=%h timeout=%b expected v=1 a=0300 timeout=1",
               cmd_valid, cmd_addr, timeout);
    end
    step();
    tests_run++;
    if ({cmd_valid, cmd_addr} !== {1'b1, 16'h0301}) begin
      tests_failed++;
      $display("FAIL wd_cmd1: got v=%b a=%h expected v=1 a=0301", cmd_valid, cmd_addr);
    end
    step();
    step();
    tests_run++;
    if (timeout !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL wd_sticky: got timeout=%b busy=%b expected 1 0", timeout, busy);
    end
    apply_reset();
    tests_run++;
    if (timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL wd_reset: got timeout=%b expected 0", timeout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_simultaneous();
    test_empty_commit();
    test_abort();
`ifdef CFG_SEQ_WATCHDOG_EN
    test_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
